// File: rtl/bypass_ctrl.sv
// Decode-stage operand bypass and load-use hazard control.
// Holds a per-register load scoreboard and a stall-run monitor with a sticky timeout flag.
module bypass_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [63:0] rf_rdata1,
    input  logic [63:0] rf_rdata2,
    input  logic        ex_valid,
    input  logic        ex_regwrite,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_dst,
    input  logic [63:0] ex_data,
    input  logic        mem_regwrite,
    input  logic        mem_is_load,
    input  logic        mem_data_ok,
    input  logic [4:0]  mem_dst,
    input  logic [63:0] mem_data,
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_dst,
    input  logic [63:0] fwd_data,
    output logic [63:0] op1,
    output logic [63:0] op2,
    output logic        hazard_stall,
    output logic [31:0] pending,
    output logic [31:0] stall_cnt,
    output logic        hazard_timeout
);

    typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  run_q, run_d;
    logic        timeout_q, timeout_d;

    logic ex_load;
    logic mem_load_ok;

    assign ex_load     = ex_valid && ex_is_load && ex_regwrite;
    assign mem_load_ok = mem_is_load && mem_data_ok;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // EX loads are never forwarded: their data is not ready until MEM.
    function automatic logic [63:0] sel_operand(input logic [4:0] rs, input logic [63:0] rf);
        if (rs == 5'd0)
            return 64'd0;
        else if (ex_valid && ex_regwrite && !ex_is_load && ex_dst == rs)
            return ex_data;
        else if (mem_regwrite && mem_dst == rs && (!mem_is_load || mem_data_ok))
            return mem_data;
        else if (fwd_valid && fwd_dst == rs)
            return fwd_data;
        else
            return rf;
    endfunction

    function automatic logic load_use(input logic [4:0] rs);
        logic mem_delivers;
        mem_delivers = mem_regwrite && mem_load_ok && mem_dst == rs;
        return (rs != 5'd0) &&
               ((ex_load && ex_dst == rs) || (pending_q[rs] && !mem_delivers));
    endfunction

    always_comb begin
        op1          = sel_operand(id_rs1, rf_rdata1);
        op2          = sel_operand(id_rs2, rf_rdata2);
        hazard_stall = id_valid && (load_use(id_rs1) || load_use(id_rs2));
    end

    // Set is applied after clear so a new load to the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (mem_load_ok)
            pending_d[mem_dst] = 1'b0;
        if (ex_load && ex_dst != 5'd0 && !stall)
            pending_d[ex_dst] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            IDLE:    if (hazard_stall)  state_d = STALL;
            STALL:   if (!hazard_stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The run count includes the cycle that enters STALL.
        if (state_d == STALL)
            run_d = sat_inc8(run_q);
        else
            run_d = 8'd0;

        if (state_d == STALL && {24'd0, run_d} == TIMEOUT)
            timeout_d = 1'b1;

        if (hazard_stall)
            stall_cnt_d = sat_inc32(stall_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 32'd0;
            stall_cnt_q <= 32'd0;
            run_q       <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            run_q       <= run_d;
            timeout_q   <= timeout_d;
        end
    end

    assign pending        = pending_q;
    assign stall_cnt      = stall_cnt_q;
    assign hazard_timeout = timeout_q;

endmodule

// File: doc/bypass_ctrl.md
BYPASS_CTRL -- requirements
Module: bypass_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the stall-run length that sets hazard_timeout.
REQ-002 SHALL have ports:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous, active-high reset
  stall  in  1  global pipeline stall from downstream
  id_valid  in  1  decode-stage instruction valid
  id_rs1, id_rs2  in  5  decode source registers
  rf_rdata1, rf_rdata2  in  64  register-file read data
  ex_valid, ex_regwrite, ex_is_load  in  1  EX-stage qualifiers
  ex_dst  in  5;  ex_data  in  64  EX result
  mem_regwrite, mem_is_load, mem_data_ok  in  1  MEM qualifiers; mem_data_ok = load data valid this cycle
  mem_dst  in  5;  mem_data  in  64  MEM result
  fwd_valid  in  1;  fwd_dst  in  5;  fwd_data  in  64  registered writeback forward entry
  op1, op2  out  64  bypassed operands
  hazard_stall  out  1  decode must hold
  pending  out  32  load scoreboard, bit n = load to xn in flight
  stall_cnt  out  32  total hazard-stall cycles, saturating
  hazard_timeout  out  1  sticky: stall run reached TIMEOUT
REQ-003 Clock port SHALL be clk; reset port SHALL be reset, synchronous and active-high.

Function
REQ-004 Operand select per source, highest priority first: rs==0 -> 0; EX match (ex_valid, ex_regwrite, !ex_is_load, ex_dst==rs) -> ex_data; MEM match (mem_regwrite, mem_dst==rs, and mem_data_ok if mem_is_load) -> mem_data; fwd match (fwd_valid, fwd_dst==rs) -> fwd_data; else rf_rdata.
REQ-005 Operand select SHALL be combinational (zero latency).
REQ-006 Load-use hazard per source (rs!=0, id_valid): ex_valid & ex_is_load & ex_regwrite & ex_dst==rs, OR pending[rs] without a same-cycle MEM load match delivering data.
REQ-007 hazard_stall SHALL be the combinational OR of REQ-006 over rs1 and rs2; 0 when id_valid=0.
REQ-008 Scoreboard set: on a cycle with ex_valid & ex_is_load & ex_regwrite & ex_dst!=0 & !stall, pending[ex_dst] SHALL be 1 next cycle.
REQ-009 Scoreboard clear: on mem_is_load & mem_data_ok, pending[mem_dst] SHALL be 0 next cycle.
REQ-010 Same-cycle set and clear of the same bit: set wins.
REQ-011 pending[0] SHALL always read 0.
REQ-012 FSM states IDLE, STALL: IDLE->STALL when hazard_stall=1; STALL->IDLE when hazard_stall=0; otherwise hold.
REQ-013 8-bit run counter: cleared on entry to IDLE, increments each cycle in STALL with hazard_stall=1, saturates at 255.
REQ-014 hazard_timeout SHALL set when the run counter reaches TIMEOUT and stay 1 until reset.
REQ-015 stall_cnt SHALL increment by 1 each cycle hazard_stall=1, saturating at 0xFFFF_FFFF.
REQ-016 The global stall input SHALL not gate hazard_stall or operand select; it gates only scoreboard set.

Reset
REQ-017 While reset=1 at a clock edge: pending=0, stall_cnt=0, run counter=0, hazard_timeout=0, state IDLE.
REQ-018 Reset during STALL SHALL return to IDLE next cycle; combinational outputs follow inputs immediately.
REQ-019 No registered output SHALL hold X after one reset cycle.

Verification
REQ-020 EX ALU x5=0x11, MEM x5=0x22, fwd x5=0x33, rs1=5 -> op1=0x11; drop EX -> 0x22; drop MEM -> 0x33; drop fwd -> rf_rdata1.
REQ-021 rs1=0, all stages writing x0 data 0xFF -> op1=0, hazard_stall=0.
REQ-022 EX load to x7 issues (stall=0), rs2=7 -> hazard_stall=1 that cycle; pending[7]=1 next; mem_data_ok with mem_data=0xABCD -> hazard_stall=0, op2=0xABCD; pending[7]=0 next cycle.
REQ-023 Load x9 sets while older load x9 clears same cycle -> pending[9]=1 next cycle.
REQ-024 TIMEOUT=4, hold hazard 6 cycles -> hazard_timeout=1 after fourth stall cycle, stall_cnt=6; remove hazard -> timeout stays 1.
REQ-025 Reset asserted mid-stall with pending=0x80 -> next cycle pending=0, stall_cnt=0, state IDLE, hazard_timeout=0.
